// File: rtl/width_pack_n.sv
// width_pack_n: packs RATIO narrow IN_W-bit beats into one wide word with
// valid/ready on both sides, selectable lane order and early flush via in_last.
module width_pack_n #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 2,
    parameter bit MSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IN_W*RATIO-1:0] out_data,
    output logic [RATIO-1:0]      out_keep,
    output logic                  out_last
);
    localparam int OW = IN_W * RATIO;
    localparam int CW = $clog2(RATIO);

    if (RATIO < 2 || RATIO > 16) begin : g_ratio_check
        $error("width_pack_n: RATIO must be in 2..16");
    end

    logic [CW-1:0]    cnt_q, cnt_d, lane;
    logic [OW-1:0]    acc_q, acc_d, acc_new, out_data_q, out_data_d;
    logic [RATIO-1:0] keep_q, keep_d, keep_new, out_keep_q, out_keep_d;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic             done, accept;

    assign lane     = MSB_FIRST ? CW'(RATIO - 1) - cnt_q : cnt_q;
    assign done     = (cnt_q == CW'(RATIO - 1)) || in_last;
    // Only a completing beat needs the output slot; partial beats always flow.
    assign in_ready = !done || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign acc_new  = acc_q | (OW'(in_data) << (lane * IN_W));
    assign keep_new = keep_q | (RATIO'(1) << lane);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        keep_d      = keep_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        if (accept && done) begin
            cnt_d       = '0;
            acc_d       = '0;
            keep_d      = '0;
            out_valid_d = 1'b1;
            out_data_d  = acc_new;
            out_keep_d  = keep_new;
            out_last_d  = in_last;
        end else if (accept) begin
            cnt_d  = cnt_q + CW'(1);
            acc_d  = acc_new;
            keep_d = keep_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            keep_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            keep_q      <= keep_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule
